// File: rtl/key_select_debounce.sv
// key_select_debounce
//   Conditions four raw, active-low, bouncing pushbuttons into a clean
//   2-bit select plus a one-cycle press strobe and debounced key levels.
//   Each key is synchronized (2 flops) and debounced by its own FSM.
//   A press is accepted only when exactly one key becomes pressed and no
//   other key is currently held, so chords never disturb the select.
//
// Ports
//   CLOCK_50   in   1  system clock, rising edge
//   RESET_N    in   1  asynchronous active-low reset
//   KEY        in   4  raw pushbuttons, 0 = pressed, asynchronous
//   SEL        out  2  last accepted select (KEY[3]->0 .. KEY[0]->3)
//   PRESS      out  1  one-cycle strobe when SEL takes an accepted value
//   VALID      out  1  sticky, set by the first accepted press
//   KEY_STATE  out  4  debounced key levels, 1 = pressed
module key_select_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] KEY,
    output logic [1:0] SEL,
    output logic       PRESS,
    output logic       VALID,
    output logic [3:0] KEY_STATE
);

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } key_fsm_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two-flop synchronizer; resets to "released" so nothing fires at reset.
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_reg <= 4'hF;
            sync2_reg <= 4'hF;
        end else begin
            sync1_reg <= KEY;
            sync2_reg <= sync1_reg;
        end
    end

    logic [3:0] enter_vec;  // key moves PRESS_PENDING -> PRESSED this edge
    logic [3:0] held_vec;   // key currently PRESSED or RELEASE_PENDING
    logic [3:0] level_vec;  // debounced level after this edge

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            key_fsm_t         state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             enter_press;
            logic             level_next;

            // State register
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    state_reg <= RELEASED;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Next-state logic; the terminal compare stops the counter
            // before it could ever wrap.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    RELEASED: begin
                        if (!sync2_reg[gi]) begin
                            state_next = PRESS_PENDING;
                            cnt_next   = '0;
                        end
                    end
                    PRESS_PENDING: begin
                        if (sync2_reg[gi]) begin
                            state_next = RELEASED;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = PRESSED;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (sync2_reg[gi]) begin
                            state_next = RELEASE_PENDING;
                            cnt_next   = '0;
                        end
                    end
                    RELEASE_PENDING: begin
                        if (!sync2_reg[gi]) begin
                            state_next = PRESSED;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = RELEASED;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = RELEASED;
                        cnt_next   = '0;
                    end
                endcase
            end

            // Output logic
            always_comb begin
                enter_press = (state_reg == PRESS_PENDING) && (state_next == PRESSED);
                level_next  = (state_next == PRESSED) || (state_next == RELEASE_PENDING);
            end

            assign enter_vec[gi] = enter_press;
            assign level_vec[gi] = level_next;
            assign held_vec[gi]  = (state_reg == PRESSED) || (state_reg == RELEASE_PENDING);
        end
    endgenerate

    // A key that is entering PRESSED is in PRESS_PENDING, so it is never in
    // held_vec itself: "no other key held" reduces to held_vec == 0.
    logic       accept;
    logic [1:0] sel_reg, sel_next;
    logic       press_reg;
    logic       valid_reg;
    logic [3:0] key_state_reg;

    always_comb begin
        accept   = (held_vec == 4'b0000) && $onehot(enter_vec);
        sel_next = sel_reg;
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (enter_vec[i]) begin
                    sel_next = 2'(3 - i);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_reg       <= 2'd0;
            press_reg     <= 1'b0;
            valid_reg     <= 1'b0;
            key_state_reg <= 4'b0000;
        end else begin
            sel_reg       <= sel_next;
            press_reg     <= accept;
            valid_reg     <= valid_reg | accept;
            key_state_reg <= level_vec;
        end
    end

    assign SEL       = sel_reg;
    assign PRESS     = press_reg;
    assign VALID     = valid_reg;
    assign KEY_STATE = key_state_reg;

endmodule

// File: tb/tb_key_select_debounce.sv
// tb_key_select_debounce
//   Directed bench for key_select_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
//   Inputs change 1 time unit after a rising edge, so the next rising edge
//   is e0; outputs are read 1 time unit after an edge. A press accepted at
//   edge e6 is therefore visible after 7 ticks.
module tb_key_select_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [1:0] sel;
    logic       press;
    logic       valid;
    logic [3:0] key_state;

    int errors = 0;
    int checks = 0;
    int press_cnt = 0;
    int base;

    key_select_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .KEY      (key),
        .SEL      (sel),
        .PRESS    (press),
        .VALID    (valid),
        .KEY_STATE(key_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts PRESS strobe cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (press) press_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("check %s: got %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 4'hF;
        tick(3);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_press", 32'(press), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_keystate", 32'(key_state), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Clean press of KEY[2]
        key = 4'b1011;
        tick(6);
        chk("clean_press_early", 32'(press), 32'd0);
        tick(1);
        chk("clean_press", 32'(press), 32'd1);
        chk("clean_sel", 32'(sel), 32'd1);
        chk("clean_valid", 32'(valid), 32'd1);
        chk("clean_keystate", 32'(key_state), 32'h4);
        tick(1);
        chk("clean_press_onecycle", 32'(press), 32'd0);
        key = 4'hF;
        tick(10);
        chk("clean_release_keystate", 32'(key_state), 32'd0);
        chk("clean_release_sel", 32'(sel), 32'd1);

        // Bounce on KEY[0]: never stable for the full window
        base = press_cnt;
        key = 4'b1110; tick(3);
        key = 4'b1111; tick(1);
        key = 4'b1110; tick(3);
        key = 4'b1111; tick(6);
        chk("bounce_no_press", 32'(press_cnt - base), 32'd0);
        chk("bounce_sel", 32'(sel), 32'd1);
        chk("bounce_keystate", 32'(key_state), 32'd0);
        key = 4'b1110;
        tick(6);
        chk("stable_press_early", 32'(press), 32'd0);
        tick(1);
        chk("stable_press", 32'(press), 32'd1);
        chk("stable_sel", 32'(sel), 32'd3);
        tick(3);
        key = 4'hF;
        tick(10);

        // Simultaneous press of KEY[3] and KEY[1]
        base = press_cnt;
        key = 4'b0101;
        tick(6);
        chk("simul_keystate_early", 32'(key_state), 32'd0);
        tick(1);
        chk("simul_keystate", 32'(key_state), 32'hA);
        chk("simul_press", 32'(press), 32'd0);
        tick(3);
        chk("simul_no_press", 32'(press_cnt - base), 32'd0);
        chk("simul_sel", 32'(sel), 32'd3);
        key = 4'hF;
        tick(10);

        // Chord: KEY[3] accepted, then KEY[1] added
        key = 4'b0111;
        tick(7);
        chk("chord_first_press", 32'(press), 32'd1);
        chk("chord_first_sel", 32'(sel), 32'd0);
        tick(1);
        base = press_cnt;
        key = 4'b0101;
        tick(10);
        chk("chord_keystate", 32'(key_state), 32'hA);
        chk("chord_no_press", 32'(press_cnt - base), 32'd0);
        chk("chord_sel", 32'(sel), 32'd0);
        key = 4'hF;
        tick(10);
        chk("chord_release_keystate", 32'(key_state), 32'd0);

        // Re-press KEY[2]
        base = press_cnt;
        key = 4'b1011;
        tick(7);
        chk("repress1_press", 32'(press), 32'd1);
        chk("repress1_sel", 32'(sel), 32'd1);
        tick(1);
        key = 4'hF;
        tick(8);
        key = 4'b1011;
        tick(7);
        chk("repress2_press", 32'(press), 32'd1);
        chk("repress2_sel", 32'(sel), 32'd1);
        tick(1);
        chk("repress_count", 32'(press_cnt - base), 32'd2);
        key = 4'hF;
        tick(10);

        // Reset while KEY[1] is in PRESS_PENDING with cnt=2 (after e4)
        key = 4'b1101;
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_press", 32'(press), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_keystate", 32'(key_state), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("postrst_press_early", 32'(press), 32'd0);
        tick(1);
        chk("postrst_press", 32'(press), 32'd1);
        chk("postrst_sel", 32'(sel), 32'd2);
        chk("postrst_valid", 32'(valid), 32'd1);
        key = 4'hF;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
